// File: rtl/digit_blink_mask_pkg.sv
// Shared clock-display definitions: digit geometry, setting positions,
// blink phase state encoding and small datapath helpers.
package digit_blink_mask_pkg;

  localparam int DIGIT_W = 7;
  localparam int DIGIT_N = 6;
  localparam int SEG_W   = DIGIT_W * DIGIT_N;

  localparam logic [1:0] POS_SEC  = 2'd0;
  localparam logic [1:0] POS_MIN  = 2'd1;
  localparam logic [1:0] POS_HOUR = 2'd2;
  localparam logic [1:0] POS_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    HIDE = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Edge counter increment that sticks at its maximum value.
  function automatic logic [3:0] cnt_inc_sat(input logic [3:0] c);
    if (c == 4'd15) begin
      return 4'd15;
    end else begin
      return c + 4'd1;
    end
  endfunction

  // Replace the digit pair under edit with the blank pattern while hidden.
  function automatic logic [SEG_W-1:0] mask_seg(
    input logic [SEG_W-1:0]   seg,
    input logic [1:0]         pos,
    input logic               phase_on,
    input logic [DIGIT_W-1:0] blank
  );
    logic [SEG_W-1:0] r;
    r = seg;
    if (!phase_on) begin
      case (pos)
        POS_SEC: begin
          r[6:0]   = blank;
          r[13:7]  = blank;
        end
        POS_MIN: begin
          r[20:14] = blank;
          r[27:21] = blank;
        end
        POS_HOUR: begin
          r[34:28] = blank;
          r[41:35] = blank;
        end
        default: begin
          r = seg;
        end
      endcase
    end else begin
      r = seg;
    end
    return r;
  endfunction

endpackage

// File: rtl/digit_blink_mask_edge_sync_det.sv
// Brings an asynchronous slow reference into the clk domain and flags its
// rising edges with a one-clk pulse. Rise-to-pulse latency is 2 clk, so the
// consuming register sees the edge on the third clk.
module edge_sync_det
  import digit_blink_mask_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchroniser followed by a history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= i_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign o_level = sync2_q;
  assign o_rise  = sync2_q & ~prev_q;

endmodule

// File: rtl/digit_blink_mask.sv
// Setting-mode blink consumer: tracks SHOW/HIDE half-periods of the blink
// reference, holds the edited digits visible after a keypress, and blanks
// the selected digit pair on the registered segment bus while hidden.
module digit_blink_mask
  import digit_blink_mask_pkg::*;
#(
  parameter int unsigned      HALF_EDGES = 32'd1,
  parameter int unsigned      HOLD_EDGES = 32'd3,
  parameter logic [DIGIT_W-1:0] BLANK    = 7'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink,
  input  logic             blink_clk,
  input  logic [1:0]       setting_position,
  input  logic [SEG_W-1:0] i_seg,
  input  logic             i_activity,
  output logic [SEG_W-1:0] o_seg,
  output logic             o_phase_on
);

  localparam logic [3:0] HALF_LAST = 4'(HALF_EDGES - 32'd1);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_EDGES - 32'd1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       pos_q;
  logic             phase_on_q, phase_on_d;
  logic [SEG_W-1:0] seg_q, seg_d;

  logic sync_level_s;
  logic sync_rise_s;
  logic edge_s;
  logic pos_chg_s;

  edge_sync_det u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (blink_clk),
    .o_level (sync_level_s),
    .o_rise  (sync_rise_s)
  );

  // A rise always implies a high level; qualifying keeps both outputs in use.
  assign edge_s    = sync_rise_s & sync_level_s;
  assign pos_chg_s = (setting_position != pos_q);

  // State, counter, position copy and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      pos_q      <= POS_SEC;
      phase_on_q <= 1'b1;
      seg_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pos_q      <= setting_position;
      phase_on_q <= phase_on_d;
      seg_q      <= seg_d;
    end
  end

  // Next-state: exit blink, keypress hold, position change, then edge counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!blink) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else if (state_q == IDLE) begin
      state_d = SHOW;
      cnt_d   = 4'd0;
    end else if (i_activity) begin
      state_d = HOLD;
      cnt_d   = 4'd0;
    end else if (pos_chg_s) begin
      state_d = SHOW;
      cnt_d   = 4'd0;
    end else if (edge_s) begin
      case (state_q)
        SHOW: begin
          if (cnt_q == HALF_LAST) begin
            state_d = HIDE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d   = cnt_inc_sat(cnt_q);
          end
        end
        HIDE: begin
          if (cnt_q == HALF_LAST) begin
            state_d = SHOW;
            cnt_d   = 4'd0;
          end else begin
            cnt_d   = cnt_inc_sat(cnt_q);
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = SHOW;
            cnt_d   = 4'd0;
          end else begin
            cnt_d   = cnt_inc_sat(cnt_q);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // Outputs: phase decode tracks the next state; mask uses the current phase.
  always_comb begin
    phase_on_d = 1'b1;
    if (state_d == HIDE) begin
      phase_on_d = 1'b0;
    end else begin
      phase_on_d = 1'b1;
    end
    seg_d = mask_seg(i_seg, setting_position, phase_on_q, BLANK);
  end

  assign o_seg      = seg_q;
  assign o_phase_on = phase_on_q;

endmodule

// File: tb/tb_digit_blink_mask.sv
// Directed bench for digit_blink_mask with default parameters
// (HALF_EDGES = 1, HOLD_EDGES = 3, BLANK = 0).
module tb_digit_blink_mask;
  import digit_blink_mask_pkg::*;

  localparam logic [41:0] SEG_ALL = 42'h3FF_FFFF_FFFF;
  localparam logic [41:0] SEG_A   = 42'h155_5555_5555;
  localparam logic [41:0] SEG_B   = 42'h2A5_A5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        blink;
  logic        blink_clk;
  logic [1:0]  setting_position;
  logic [41:0] i_seg;
  logic        i_activity;
  logic [41:0] o_seg;
  logic        o_phase_on;

  logic [41:0] exp_seg;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_blink_mask dut (
    .clk              (clk),
    .rst              (rst),
    .blink            (blink),
    .blink_clk        (blink_clk),
    .setting_position (setting_position),
    .i_seg            (i_seg),
    .i_activity       (i_activity),
    .o_seg            (o_seg),
    .o_phase_on       (o_phase_on)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ph(input string tag, input logic exp);
    chk(tag, {41'd0, o_phase_on}, {41'd0, exp});
  endtask

  task automatic chk_st(input string tag, input state_e exp);
    chk(tag, {40'd0, dut.state_q}, {40'd0, exp});
  endtask

  // blink_clk rise, then wait until the resulting edge has been consumed.
  task automatic rise();
    blink_clk = 1'b1;
    tick(3);
  endtask

  task automatic fall();
    blink_clk = 1'b0;
    tick(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- reset and idle pass-through ----
    rst = 1'b1; blink = 1'b0; blink_clk = 1'b0; i_activity = 1'b0;
    setting_position = POS_NONE; i_seg = SEG_ALL;
    #12;
    chk("rst_seg", o_seg, 42'd0);
    chk_ph("rst_phase", 1'b1);
    chk_st("rst_state", IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1);
    chk("idle_pass", o_seg, SEG_ALL);
    for (int i = 0; i < 5; i++) begin
      rise();
      chk_ph("idle_phase", 1'b1);
      chk_st("idle_state", IDLE);
      chk("idle_seg", o_seg, SEG_ALL);
      fall();
    end

    // ---- blinking on minutes ----
    setting_position = POS_MIN; i_seg = SEG_A; blink = 1'b1;
    tick(1);
    chk_st("enter_show", SHOW);
    chk_ph("enter_show_ph", 1'b1);
    blink_clk = 1'b1;
    tick(2);
    chk_ph("lat2_still_on", 1'b1);
    tick(1);
    chk_ph("lat3_hide", 1'b0);
    tick(1);
    exp_seg = SEG_A; exp_seg[27:14] = 14'd0;
    chk("hide_min_seg", o_seg, exp_seg);
    fall();
    rise();
    chk_ph("show_again", 1'b1);
    tick(1);
    chk("show_seg", o_seg, SEG_A);
    fall();
    rise();
    chk_ph("hide_again", 1'b0);
    fall();

    // ---- keypress hold ----
    i_activity = 1'b1;
    tick(1);
    i_activity = 1'b0;
    chk_ph("hold_ph", 1'b1);
    chk_st("hold_state", HOLD);
    for (int k = 1; k <= 3; k++) begin
      rise();
      chk_ph("hold_edge_ph", 1'b1);
      chk_st("hold_edge_state", (k < 3) ? HOLD : SHOW);
      fall();
    end
    rise();
    chk_ph("after_hold_hide", 1'b0);
    chk_st("after_hold_state", HIDE);
    fall();

    // ---- position changes ----
    setting_position = POS_SEC;
    tick(1);
    chk_st("pos_sec_show", SHOW);
    rise();
    chk_ph("pos_sec_hide", 1'b0);
    tick(1);
    exp_seg = SEG_A; exp_seg[13:0] = 14'd0;
    chk("hide_sec_seg", o_seg, exp_seg);
    fall();
    setting_position = POS_HOUR; i_seg = SEG_B;
    tick(1);
    chk_st("pos_hour_show", SHOW);
    chk_ph("pos_hour_ph", 1'b1);
    tick(1);
    chk("pos_hour_unmasked", o_seg, SEG_B);
    rise();
    chk_ph("pos_hour_hide", 1'b0);
    tick(1);
    exp_seg = SEG_B; exp_seg[41:28] = 14'd0;
    chk("hide_hour_seg", o_seg, exp_seg);
    fall();
    setting_position = POS_NONE;
    tick(1);
    chk_st("pos_none_show", SHOW);
    rise();
    chk_ph("pos_none_hide", 1'b0);
    tick(1);
    chk("pos_none_seg", o_seg, SEG_B);
    fall();

    // ---- blink drop with coincident blink_clk rise ----
    blink = 1'b0; blink_clk = 1'b1;
    tick(1);
    chk_st("drop_idle", IDLE);
    chk_ph("drop_ph", 1'b1);
    tick(1);
    chk("drop_seg", o_seg, SEG_B);
    tick(2);
    chk_st("drop_edge_ignored", IDLE);
    chk_ph("drop_edge_ph", 1'b1);
    fall();

    // ---- asynchronous reset mid-HIDE ----
    setting_position = POS_HOUR; blink = 1'b1;
    tick(1);
    chk_st("pre_rst_show", SHOW);
    rise();
    tick(1);
    chk("pre_rst_hide_seg", o_seg, exp_seg);
    fall();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_seg", o_seg, 42'd0);
    chk_ph("async_rst_ph", 1'b1);
    tick(1);
    chk("rst_held_seg", o_seg, 42'd0);
    rst = 1'b0;
    chk_st("release_idle", IDLE);
    tick(1);
    chk_st("release_show", SHOW);
    chk_ph("release_ph", 1'b1);
    tick(1);
    chk("release_seg", o_seg, SEG_B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
